// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end for a single-port RAM: deserialises command frames and serialises read data.
// Define SPI_SLAVE_SVA_EN to compile in the concurrent protocol assertions.
module spi_slave_ctrl #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   SS_n,
    input  logic                   MOSI,
    input  logic                   tx_valid,
    input  logic [ADDR_SIZE-1:0]   tx_data,
    output logic [ADDR_SIZE+1:0]   rx_data,
    output logic                   rx_valid,
    output logic                   MISO
);

    localparam int FRAME = ADDR_SIZE + 2;
    localparam int CW    = $clog2(FRAME + 1);
    localparam int TW    = $clog2(ADDR_SIZE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK_CMD,
        S_WRITE,
        S_READ_ADD,
        S_READ_DATA
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [FRAME-1:0]     rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rad_q, rad_d;
    logic [ADDR_SIZE-1:0] tx_shift_q, tx_shift_d;
    logic [TW-1:0]        tx_left_q, tx_left_d;
    logic                 tx_taken_q, tx_taken_d;

    logic shifting;
    logic frame_open;
    logic last_bit;

    assign shifting   = (state_q == S_WRITE) || (state_q == S_READ_ADD) ||
                        (state_q == S_READ_DATA);
    assign frame_open = shifting && (cnt_q != CW'(FRAME));
    assign last_bit   = frame_open && (cnt_q == CW'(FRAME - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (SS_n) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    state_d = S_CHK_CMD;
                S_CHK_CMD: state_d = !MOSI ? S_WRITE : (rad_q ? S_READ_DATA : S_READ_ADD);
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        rx_data  = rx_data_q;
        rx_valid = rx_valid_q;
        MISO     = (state_q == S_READ_DATA) && (tx_left_q != '0) && tx_shift_q[ADDR_SIZE-1];
    end

    // Frame capture first; only once the frame is complete does READ_DATA arm or run the transmitter.
    always_comb begin
        cnt_d      = cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rad_d      = rad_q;
        tx_shift_d = tx_shift_q;
        tx_left_d  = tx_left_q;
        tx_taken_d = tx_taken_q;
        if (SS_n || (state_q == S_IDLE)) begin
            cnt_d      = '0;
            tx_left_d  = '0;
            tx_taken_d = 1'b0;
        end else if (frame_open) begin
            rx_data_d = {rx_data_q[FRAME-2:0], MOSI};
            cnt_d     = cnt_q + 1'b1;
            if (last_bit) begin
                rx_valid_d = 1'b1;
                if (state_q == S_READ_ADD)  rad_d = 1'b1;
                if (state_q == S_READ_DATA) rad_d = 1'b0;
            end
        end else if (state_q == S_READ_DATA) begin
            if (tx_left_q != '0) begin
                tx_shift_d = tx_shift_q << 1;
                tx_left_d  = tx_left_q - 1'b1;
            end else if (!tx_taken_q && tx_valid) begin
                tx_shift_d = tx_data;
                tx_left_d  = TW'(ADDR_SIZE);
                tx_taken_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rad_q      <= 1'b0;
            tx_left_q  <= '0;
            tx_taken_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rad_q      <= rad_d;
            tx_left_q  <= tx_left_d;
            tx_taken_q <= tx_taken_d;
        end
    end

    // Pure data: MISO is gated by tx_left_q, so this needs no reset.
    always_ff @(posedge clk) begin
        tx_shift_q <= tx_shift_d;
    end

`ifdef SPI_SLAVE_SVA_EN
    a_reset_outputs: assert property (@(posedge clk)
        !rst_n |-> (rx_data == '0 && !rx_valid && !MISO));
    a_rx_valid_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        rx_valid |=> !rx_valid);
    a_ss_idle: assert property (@(posedge clk) disable iff (!rst_n)
        SS_n |=> (state_q == S_IDLE));
    a_read_data_entry: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q != S_READ_DATA && state_d == S_READ_DATA) |-> rad_q);
    a_miso_window: assert property (@(posedge clk) disable iff (!rst_n)
        MISO |-> (state_q == S_READ_DATA && tx_left_q != '0));
`endif

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Self-checking bench for spi_slave_ctrl: directed frames plus randomized traffic vs a frame-level model.
module tb_spi_slave_ctrl;

    localparam int AW = 8;

    logic          clk;
    logic          rst_n;
    logic          SS_n;
    logic          MOSI;
    logic          tx_valid;
    logic [AW-1:0] tx_data;
    logic [AW+1:0] rx_data;
    logic          rx_valid;
    logic          MISO;

    int n_checks = 0;
    int n_errors = 0;

    // Frame-level reference state
    int pos;
    int kind;
    int word;
    bit rad;
    bit taken;
    bit m_valid;
    bit m_miso;
    int m_rx;
    bit mq[$];

    spi_slave_ctrl #(.ADDR_SIZE(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .MISO     (MISO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        pos     = 0;
        kind    = 0;
        word    = 0;
        rad     = 1'b0;
        taken   = 1'b0;
        m_valid = 1'b0;
        m_miso  = 1'b0;
        m_rx    = 0;
        mq.delete();
    endtask

    // One clock edge of the SPI frame rules: edge 1 of a select burst leaves IDLE,
    // edge 2 picks the frame kind, edges 3..12 collect the word, later edges may transmit.
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
            m_valid = 1'b0;
            if (SS_n) begin
                pos   = 0;
                taken = 1'b0;
                mq.delete();
            end else begin
                pos++;
                if (pos == 2) begin
                    kind = (MOSI == 1'b0) ? 0 : (rad ? 2 : 1);
                    word = 0;
                end else if (pos >= 3 && pos <= AW + 4) begin
                    word = (word * 2 + int'(MOSI)) % (1 << (AW + 2));
                    if (pos == AW + 4) begin
                        m_valid = 1'b1;
                        m_rx    = word;
                        if (kind == 1) rad = 1'b1;
                        if (kind == 2) rad = 1'b0;
                    end
                end else if (pos > AW + 4 && kind == 2 && !taken && tx_valid) begin
                    taken = 1'b1;
                    for (int i = AW - 1; i >= 0; i--)
                        mq.push_back(((int'(tx_data) / (1 << i)) % 2) == 1);
                end
            end
            m_miso = (mq.size() > 0) ? mq.pop_front() : 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("rx_valid", 32'(rx_valid), 32'(m_valid));
        check("MISO", 32'(MISO), 32'(m_miso));
        if (m_valid || !rst_n) check("rx_data", 32'(rx_data), 32'(m_rx));
    endtask

    task automatic drive(input logic ss, input logic mosi, input logic txv, input logic [AW-1:0] txd);
        SS_n     = ss;
        MOSI     = mosi;
        tx_valid = txv;
        tx_data  = txd;
        step();
    endtask

    task automatic send(input logic sel, input logic [AW+1:0] w, input int nbits);
        drive(1'b0, 1'b0, 1'b0, '0);
        drive(1'b0, sel, 1'b0, '0);
        for (int i = 0; i < nbits; i++) drive(1'b0, w[AW+1-i], 1'b0, '0);
    endtask

    initial begin
        logic [AW-1:0] xx;
        logic [AW-1:0] txv;
        int low_left;
        int rst_left;

        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        model_reset();

        for (int i = 0; i < 100; i++)
            drive(1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom));
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_miso", 32'(MISO), 32'h0);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, '0);

        send(1'b0, 10'h0A5, 10);
        check("wr_addr_data", 32'(rx_data), 32'h0A5);
        check("wr_addr_vld", 32'(rx_valid), 32'h1);
        drive(1'b0, 1'b1, 1'b0, '0);
        check("wr_addr_pulse", 32'(rx_valid), 32'h0);
        check("wr_addr_hold", 32'(rx_data), 32'h0A5);
        drive(1'b1, 1'b0, 1'b0, '0);

        send(1'b0, 10'h13C, 10);
        check("wr_data_data", 32'(rx_data), 32'h13C);
        check("wr_data_vld", 32'(rx_valid), 32'h1);
        drive(1'b1, 1'b0, 1'b0, '0);

        send(1'b1, 10'h25A, 10);
        check("rd_addr_data", 32'(rx_data), 32'h25A);
        check("rd_addr_vld", 32'(rx_valid), 32'h1);
        drive(1'b1, 1'b0, 1'b0, '0);

        xx = AW'($urandom);
        send(1'b1, {2'b11, xx}, 10);
        check("rd_data_data", 32'(rx_data), 32'({2'b11, xx}));
        check("rd_data_vld", 32'(rx_valid), 32'h1);
        drive(1'b0, 1'b0, 1'b0, '0);
        check("rd_miso_wait", 32'(MISO), 32'h0);
        txv = 8'hC3;
        drive(1'b0, 1'b0, 1'b1, txv);
        check("rd_miso_b7", 32'(MISO), 32'(txv[7]));
        for (int i = 6; i >= 0; i--) begin
            drive(1'b0, 1'b0, 1'b0, '0);
            check("rd_miso_bit", 32'(MISO), 32'(txv[i]));
        end
        drive(1'b0, 1'b0, 1'b1, 8'hFF);
        check("rd_miso_end", 32'(MISO), 32'h0);
        drive(1'b1, 1'b0, 1'b0, '0);

        send(1'b0, 10'h3FF, 5);
        drive(1'b1, 1'b1, 1'b0, '0);
        check("abort_vld", 32'(rx_valid), 32'h0);
        check("abort_miso", 32'(MISO), 32'h0);
        drive(1'b1, 1'b1, 1'b0, '0);
        send(1'b0, 10'h155, 10);
        check("post_abort_data", 32'(rx_data), 32'h155);
        check("post_abort_vld", 32'(rx_valid), 32'h1);
        drive(1'b1, 1'b0, 1'b0, '0);

        send(1'b0, 10'h2AA, 9);
        drive(1'b1, 1'b0, 1'b0, '0);
        check("ss_wins_vld", 32'(rx_valid), 32'h0);
        drive(1'b1, 1'b0, 1'b0, '0);

        low_left = 0;
        rst_left = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic ss;
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                model_reset();
                rst_left = $urandom_range(1, 3);
            end
            if (low_left > 0) begin
                ss = 1'b0;
                low_left--;
            end else begin
                ss = 1'b1;
                if ($urandom_range(0, 2) == 0) low_left = $urandom_range(2, 30);
            end
            drive(ss, 1'($urandom), ($urandom_range(0, 3) == 0), AW'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
